mem_bus_seq: RTL

- Memory/I-O sequencer directly downstream of the execution stage.
- Consumes the per-micro-op memory request: addr, wr_data, we, m_io, byteop, plus the micro-op's mem_op bit as req.
- Runs it on a 16-bit word-addressed bus with byte selects, and splits odd-address word accesses into two bus cycles, as the 8086 does.
- Returns read data on memout; pulses mem_rdy so the exec stage's register-write block is released.

---
 rtl/mem_bus_seq_if.sv | 14 +
 rtl/mem_bus_seq.sv | 91 +++++++++
 2 files changed

// File: rtl/mem_bus_seq_if.sv
// mem_bus_seq_if: 16-bit word-addressed bus with byte lane selects and I/O address tag
interface mem_bus_seq_if;
  logic [18:0] adr;
  logic [15:0] dat_o;
  logic [15:0] dat_i;
  logic [1:0]  sel;
  logic        we;
  logic        tga;
  logic        stb;
  logic        cyc;
  logic        ack;
  modport master (output adr, dat_o, sel, we, tga, stb, cyc, input dat_i, ack);
  modport slave  (input adr, dat_o, sel, we, tga, stb, cyc, output dat_i, ack);
endinterface

// File: rtl/mem_bus_seq.sv
// mem_bus_seq: memory/I-O sequencer splitting odd-address word accesses into two bus cycles
module mem_bus_seq #(
  parameter int WDOG_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [19:0]   i_addr,
  input  logic [15:0]   i_wr_data,
  input  logic          i_we,
  input  logic          i_m_io,
  input  logic          i_byteop,
  output logic [15:0]   o_memout,
  output logic          o_mem_rdy,
  output logic          o_bus_err,
  mem_bus_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, CYC1, CYC2, DONE} state_t;
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
  state_t            r_state;
  logic              r_odd;
  logic              r_byte;
  logic              r_split;
  logic [7:0]        r_lo;
  logic [WDOG_W-1:0] r_wdog;
  logic [7:0]        w_lane;
  logic [15:0]       w_rd;
  assign w_lane = r_odd ? bus.dat_i[15:8] : bus.dat_i[7:0];
  assign w_rd   = r_state == CYC2 ? {bus.dat_i[7:0], r_lo} : r_byte ? {8'h00, w_lane} : bus.dat_i;
  // Odd word data goes out byte-swapped so each half finds its byte on the lane it strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_odd     <= 1'b0;
      r_byte    <= 1'b0;
      r_split   <= 1'b0;
      r_lo      <= '0;
      r_wdog    <= '0;
      o_memout  <= '0;
      o_mem_rdy <= 1'b0;
      o_bus_err <= 1'b0;
      bus.adr   <= '0;
      bus.dat_o <= '0;
      bus.sel   <= '0;
      bus.we    <= 1'b0;
      bus.tga   <= 1'b0;
      bus.stb   <= 1'b0;
      bus.cyc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_req) begin
          r_state   <= CYC1;
          r_odd     <= i_addr[0];
          r_byte    <= i_byteop;
          r_split   <= !i_byteop && i_addr[0];
          r_wdog    <= '0;
          bus.stb   <= 1'b1;
          bus.cyc   <= 1'b1;
          bus.we    <= i_we;
          bus.tga   <= i_m_io;
          bus.adr   <= i_addr[19:1];
          bus.sel   <= i_addr[0] ? 2'b10 : i_byteop ? 2'b01 : 2'b11;
          bus.dat_o <= i_byteop ? {2{i_wr_data[7:0]}} :
                       i_addr[0] ? {i_wr_data[7:0], i_wr_data[15:8]} : i_wr_data;
        end
        CYC1, CYC2: if (bus.ack && r_state == CYC1 && r_split) begin
          r_state <= CYC2;
          r_lo    <= bus.dat_i[15:8];
          r_wdog  <= '0;
          bus.adr <= bus.adr + 19'd1;
          bus.sel <= 2'b01;
        end else if (bus.ack || r_wdog == WDOG_LAST) begin
          r_state   <= DONE;
          bus.stb   <= 1'b0;
          bus.cyc   <= 1'b0;
          o_mem_rdy <= 1'b1;
          o_bus_err <= !bus.ack;
          if (!bus.ack) o_memout <= 16'hFFFF;
          else if (!bus.we) o_memout <= w_rd;
        end else begin
          r_wdog <= r_wdog + WDOG_W'(1);
        end
        DONE: begin
          r_state   <= IDLE;
          o_mem_rdy <= 1'b0;
          o_bus_err <= 1'b0;
        end
      endcase
    end
  end
endmodule
